// File: rtl/reorder_buffer_pkg.sv
// Shared reorder-buffer constants: tag sizing and instruction type codes used by the
// dispatcher, reservation stations, load/store buffer and the ROB itself.
package reorder_buffer_pkg;

    localparam int ROB_TAG_W = 4;
    localparam int ROB_DEPTH = 1 << ROB_TAG_W;

    typedef enum logic [2:0] {
        ROB_ALU    = 3'd0,
        ROB_LOAD   = 3'd1,
        ROB_STORE  = 3'd2,
        ROB_BRANCH = 3'd3,
        ROB_JUMP   = 3'd4
    } rob_type_e;

    // Types that produce an architectural register result (JUMP writes its link address).
    function automatic logic writes_rd(input logic [2:0] t);
        return (t == ROB_ALU) || (t == ROB_LOAD) || (t == ROB_JUMP);
    endfunction

endpackage

// File: rtl/reorder_buffer.sv
// In-order retirement queue: allocates tags at dispatch, captures out-of-order results,
// broadcasts ready values for operand capture and retires one instruction per cycle.
module reorder_buffer
    import reorder_buffer_pkg::*;
#(
    parameter int TAG_W = ROB_TAG_W,
    parameter int XLEN  = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        issue_valid,
    output logic                        issue_ready,
    input  logic [2:0]                  issue_type,
    input  logic [4:0]                  issue_rd,
    output logic [TAG_W-1:0]            alloc_tag,
    input  logic                        rs_wb_valid,
    input  logic [TAG_W-1:0]            rs_wb_tag,
    input  logic [XLEN-1:0]             rs_wb_value,
    input  logic                        rs_wb_mispredict,
    input  logic [XLEN-1:0]             rs_wb_target,
    input  logic                        lsb_wb_valid,
    input  logic [TAG_W-1:0]            lsb_wb_tag,
    input  logic [XLEN-1:0]             lsb_wb_value,
    output logic [(1<<TAG_W)-1:0]       rob_valid,
    output logic [(1<<TAG_W)*XLEN-1:0]  rob_value,
    output logic                        commit_valid,
    output logic                        commit_we,
    output logic [4:0]                  commit_rd,
    output logic [XLEN-1:0]             commit_value,
    output logic [TAG_W-1:0]            commit_tag,
    output logic                        store_commit,
    output logic [TAG_W-1:0]            store_commit_tag,
    output logic                        flush,
    output logic [XLEN-1:0]             flush_pc,
    output logic                        empty,
    output logic                        full
);

    localparam int DEPTH = 1 << TAG_W;

    logic [TAG_W-1:0] head, tail;
    logic [TAG_W:0]   count, count_next;

    logic [DEPTH-1:0] busy, ready, mispred;
    logic [2:0]       etype   [DEPTH];
    logic [4:0]       erd     [DEPTH];
    logic [XLEN-1:0]  evalue  [DEPTH];
    logic [XLEN-1:0]  etarget [DEPTH];

    logic head_commit, flush_pending, issue_fire, lsb_take;

    assign empty         = (count == '0);
    assign full          = (count == (TAG_W+1)'(DEPTH));
    assign head_commit   = busy[head] & ready[head];
    assign flush_pending = head_commit & mispred[head];
    assign issue_ready   = !full && !flush && !flush_pending;
    assign issue_fire    = issue_valid && issue_ready;
    assign alloc_tag     = tail;
    assign lsb_take      = lsb_wb_valid && busy[lsb_wb_tag]
                           && !(rs_wb_valid && rs_wb_tag == lsb_wb_tag);

    always_comb begin
        count_next = count;
        if (issue_fire && !head_commit)
            count_next = count + 1'b1;
        else if (!issue_fire && head_commit)
            count_next = count - 1'b1;
    end

    // Later assignments win: issue overrides nothing live, commit frees head, and a
    // mispredict flush overrides every writeback and allocation of the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            head             <= '0;
            tail             <= '0;
            count            <= '0;
            busy             <= '0;
            ready            <= '0;
            mispred          <= '0;
            commit_valid     <= 1'b0;
            commit_we        <= 1'b0;
            commit_rd        <= '0;
            commit_value     <= '0;
            commit_tag       <= '0;
            store_commit     <= 1'b0;
            store_commit_tag <= '0;
            flush            <= 1'b0;
            flush_pc         <= '0;
        end else begin
            commit_valid <= 1'b0;
            commit_we    <= 1'b0;
            store_commit <= 1'b0;
            flush        <= 1'b0;
            count        <= count_next;

            if (rs_wb_valid && busy[rs_wb_tag]) begin
                ready[rs_wb_tag]   <= 1'b1;
                evalue[rs_wb_tag]  <= rs_wb_value;
                mispred[rs_wb_tag] <= rs_wb_mispredict;
                etarget[rs_wb_tag] <= rs_wb_target;
            end
            if (lsb_take) begin
                ready[lsb_wb_tag]   <= 1'b1;
                evalue[lsb_wb_tag]  <= lsb_wb_value;
                mispred[lsb_wb_tag] <= 1'b0;
            end

            if (issue_fire) begin
                busy[tail]    <= 1'b1;
                ready[tail]   <= 1'b0;
                mispred[tail] <= 1'b0;
                etype[tail]   <= issue_type;
                erd[tail]     <= issue_rd;
                tail          <= tail + 1'b1;
            end

            if (head_commit) begin
                commit_valid <= 1'b1;
                commit_tag   <= head;
                commit_rd    <= erd[head];
                commit_value <= evalue[head];
                commit_we    <= writes_rd(etype[head]) && (erd[head] != 5'd0);
                if (etype[head] == ROB_STORE) begin
                    store_commit     <= 1'b1;
                    store_commit_tag <= head;
                end
                busy[head]  <= 1'b0;
                ready[head] <= 1'b0;
                head        <= head + 1'b1;
                if (mispred[head]) begin
                    flush    <= 1'b1;
                    flush_pc <= etarget[head];
                    busy     <= '0;
                    ready    <= '0;
                    head     <= '0;
                    tail     <= '0;
                    count    <= '0;
                end
            end
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_bcast
        assign rob_valid[i]              = busy[i] & ready[i];
        assign rob_value[XLEN*i +: XLEN] = evalue[i];
    end

endmodule
